// File: rtl/exec_arbiter.sv
// Two-requester round-robin arbiter in front of one combinational execution unit.
// Each operation occupies the unit for one EXEC cycle; results land in per-requester response slots.
module exec_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 7,
    parameter int BR_LO  = 20,
    parameter int BR_HI  = 25
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [DATA_W-1:0] a_op1,
    input  logic [DATA_W-1:0] a_op2,
    input  logic [OP_W-1:0]   a_opcode,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [DATA_W-1:0] b_op1,
    input  logic [DATA_W-1:0] b_op2,
    input  logic [OP_W-1:0]   b_opcode,
    output logic [DATA_W-1:0] eu_op1,
    output logic [DATA_W-1:0] eu_op2,
    output logic [OP_W-1:0]   eu_opcode,
    input  logic [DATA_W-1:0] eu_result,
    output logic              a_rsp_valid,
    input  logic              a_rsp_ready,
    output logic [DATA_W-1:0] a_rsp_result,
    output logic              a_rsp_branch,
    output logic              b_rsp_valid,
    input  logic              b_rsp_ready,
    output logic [DATA_W-1:0] b_rsp_result,
    output logic              b_rsp_branch,
    output logic              busy
);

    // Handshake: a transfer happens on a rising edge where x_valid and x_ready are both high.
    // ready never depends on a future cycle; valid may drop at any time without effect.
    typedef enum logic {IDLE, EXEC} state_t;

    localparam logic [OP_W-1:0]   BR_LO_C = OP_W'(BR_LO);
    localparam logic [OP_W-1:0]   BR_HI_C = OP_W'(BR_HI);
    localparam logic [DATA_W-1:0] ONE_C   = DATA_W'(1);

    state_t            state;
    state_t            state_next;
    logic              ptr_b;
    logic              gnt_b;
    logic [DATA_W-1:0] op1_r;
    logic [DATA_W-1:0] op2_r;
    logic [OP_W-1:0]   opc_r;
    logic              a_elig;
    logic              b_elig;
    logic              a_hs;
    logic              b_hs;
    logic              is_branch;

    // A slot being drained this cycle counts as free, so back-to-back requests are not stalled.
    assign a_elig = a_valid && (!a_rsp_valid || a_rsp_ready);
    assign b_elig = b_valid && (!b_rsp_valid || b_rsp_ready);
    assign a_hs   = a_valid && a_ready;
    assign b_hs   = b_valid && b_ready;

    always_comb begin
        state_next = state;
        a_ready    = 1'b0;
        b_ready    = 1'b0;
        case (state)
            IDLE: begin
                if (rst_n) begin
                    if (a_elig && (!b_elig || !ptr_b)) begin
                        a_ready = 1'b1;
                    end else if (b_elig) begin
                        b_ready = 1'b1;
                    end
                end
                if ((a_valid && a_ready) || (b_valid && b_ready)) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy      = (state == EXEC);
    assign eu_op1    = busy ? op1_r : '0;
    assign eu_op2    = busy ? op2_r : '0;
    assign eu_opcode = busy ? opc_r : '0;
    assign is_branch = (opc_r >= BR_LO_C) && (opc_r <= BR_HI_C) && (eu_result == ONE_C);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr_b <= 1'b0;
            gnt_b <= 1'b0;
            op1_r <= '0;
            op2_r <= '0;
            opc_r <= '0;
        end else begin
            state <= state_next;
            if (a_hs) begin
                op1_r <= a_op1;
                op2_r <= a_op2;
                opc_r <= a_opcode;
                gnt_b <= 1'b0;
                ptr_b <= 1'b1;
            end else if (b_hs) begin
                op1_r <= b_op1;
                op2_r <= b_op2;
                opc_r <= b_opcode;
                gnt_b <= 1'b1;
                ptr_b <= 1'b0;
            end
        end
    end

    // Refill takes priority over drain so a same-edge drain+refill keeps valid high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_rsp_valid  <= 1'b0;
            a_rsp_result <= '0;
            a_rsp_branch <= 1'b0;
            b_rsp_valid  <= 1'b0;
            b_rsp_result <= '0;
            b_rsp_branch <= 1'b0;
        end else begin
            if (busy && !gnt_b) begin
                a_rsp_valid  <= 1'b1;
                a_rsp_result <= eu_result;
                a_rsp_branch <= is_branch;
            end else if (a_rsp_valid && a_rsp_ready) begin
                a_rsp_valid <= 1'b0;
            end
            if (busy && gnt_b) begin
                b_rsp_valid  <= 1'b1;
                b_rsp_result <= eu_result;
                b_rsp_branch <= is_branch;
            end else if (b_rsp_valid && b_rsp_ready) begin
                b_rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_exec_arbiter.sv
// Bench for exec_arbiter: vector table for single operations plus hand-written sequences
// for arbitration, backpressure, reset abort and back-to-back refill.
module tb_exec_arbiter;

    localparam int DATA_W = 32;
    localparam int OP_W   = 7;

    logic              clk;
    logic              rst_n;
    logic              a_valid, b_valid;
    logic              a_ready, b_ready;
    logic [DATA_W-1:0] a_op1, a_op2, b_op1, b_op2;
    logic [OP_W-1:0]   a_opcode, b_opcode;
    logic [DATA_W-1:0] eu_op1, eu_op2, eu_result;
    logic [OP_W-1:0]   eu_opcode;
    logic              a_rsp_valid, b_rsp_valid;
    logic              a_rsp_ready, b_rsp_ready;
    logic [DATA_W-1:0] a_rsp_result, b_rsp_result;
    logic              a_rsp_branch, b_rsp_branch;
    logic              busy;

    int checks = 0;
    int errors = 0;

    logic [DATA_W:0] exp_a_q[$];
    logic [DATA_W:0] exp_b_q[$];

    typedef struct {
        logic              src_b;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic [OP_W-1:0]   opc;
        logic [DATA_W-1:0] exp_result;
        logic              exp_branch;
    } vec_t;

    vec_t vecs[10];

    exec_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W), .BR_LO(20), .BR_HI(25)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_op1(a_op1), .a_op2(a_op2), .a_opcode(a_opcode),
        .b_valid(b_valid), .b_ready(b_ready), .b_op1(b_op1), .b_op2(b_op2), .b_opcode(b_opcode),
        .eu_op1(eu_op1), .eu_op2(eu_op2), .eu_opcode(eu_opcode), .eu_result(eu_result),
        .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready),
        .a_rsp_result(a_rsp_result), .a_rsp_branch(a_rsp_branch),
        .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready),
        .b_rsp_result(b_rsp_result), .b_rsp_branch(b_rsp_branch),
        .busy(busy)
    );

    // Execution unit model: addition for every opcode.
    assign eu_result = eu_op1 + eu_op2;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic model_branch(input logic [OP_W-1:0] opc, input logic [DATA_W-1:0] res);
        return (opc >= 7'd20) && (opc <= 7'd25) && (res == 32'd1);
    endfunction

    // scoreboard: push on request handshake, pop on response drain
    always @(negedge clk) begin
        logic [DATA_W:0] e;
        if (!rst_n) begin
            exp_a_q.delete();
            exp_b_q.delete();
        end else begin
            if (a_valid && a_ready)
                exp_a_q.push_back({model_branch(a_opcode, a_op1 + a_op2), a_op1 + a_op2});
            if (b_valid && b_ready)
                exp_b_q.push_back({model_branch(b_opcode, b_op1 + b_op2), b_op1 + b_op2});
            if (a_rsp_valid && a_rsp_ready) begin
                if (exp_a_q.size() == 0) begin
                    check("a_rsp_unexpected", 64'(exp_a_q.size()), 64'd1);
                end else begin
                    e = exp_a_q.pop_front();
                    check("a_rsp_sb", {31'd0, a_rsp_branch, a_rsp_result}, {31'd0, e});
                end
            end
            if (b_rsp_valid && b_rsp_ready) begin
                if (exp_b_q.size() == 0) begin
                    check("b_rsp_unexpected", 64'(exp_b_q.size()), 64'd1);
                end else begin
                    e = exp_b_q.pop_front();
                    check("b_rsp_sb", {31'd0, b_rsp_branch, b_rsp_result}, {31'd0, e});
                end
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n   = 1'b0;
        a_valid = 1'b1;
        b_valid = 1'b1;
        tick();
        #1;
        check("rst_a_ready", a_ready, 1'b0);
        check("rst_b_ready", b_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_a_rsp_valid", a_rsp_valid, 1'b0);
        check("rst_b_rsp_valid", b_rsp_valid, 1'b0);
        check("rst_a_rsp_result", a_rsp_result, 32'd0);
        check("rst_eu", {eu_op1, eu_op2}, 64'd0);
        check("rst_eu_opcode", eu_opcode, 7'd0);
        tick();
        rst_n   = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic drive_req(input logic src_b, input logic [DATA_W-1:0] op1,
                             input logic [DATA_W-1:0] op2, input logic [OP_W-1:0] opc);
        if (src_b) begin
            b_op1 = op1; b_op2 = op2; b_opcode = opc; b_valid = 1'b1; a_valid = 1'b0;
        end else begin
            a_op1 = op1; a_op2 = op2; a_opcode = opc; a_valid = 1'b1; b_valid = 1'b0;
        end
    endtask

    // Returns in the cycle of the grant, before the handshake edge.
    task automatic wait_grant(input logic src_b);
        int k = 0;
        #1;
        while (!(src_b ? b_ready : a_ready) && k < 20) begin
            tick();
            #1;
            k++;
        end
        check(src_b ? "b_grant" : "a_grant", src_b ? b_ready : a_ready, 1'b1);
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'd5,          32'd7,  7'd0,  32'd12,         1'b0};
        vecs[1] = '{1'b1, 32'd100,        32'd23, 7'd1,  32'd123,        1'b0};
        vecs[2] = '{1'b0, 32'd1,          32'd0,  7'd22, 32'd1,          1'b1};
        vecs[3] = '{1'b1, 32'd2,          32'd0,  7'd22, 32'd2,          1'b0};
        vecs[4] = '{1'b0, 32'd1,          32'd0,  7'd19, 32'd1,          1'b0};
        vecs[5] = '{1'b1, 32'd0,          32'd1,  7'd26, 32'd1,          1'b0};
        vecs[6] = '{1'b0, 32'd1,          32'd0,  7'd20, 32'd1,          1'b1};
        vecs[7] = '{1'b1, 32'd0,          32'd1,  7'd25, 32'd1,          1'b1};
        vecs[8] = '{1'b0, 32'hffff_ffff,  32'd2,  7'd22, 32'd1,          1'b1};
        vecs[9] = '{1'b1, 32'hffff_ffff,  32'd0,  7'd21, 32'hffff_ffff,  1'b0};

        a_op1 = '0; a_op2 = '0; a_opcode = '0;
        b_op1 = '0; b_op2 = '0; b_opcode = '0;
        a_rsp_ready = 1'b1;
        b_rsp_ready = 1'b1;
        reset_dut();

        // single operations from the table, with latency and EU drive checks
        for (int i = 0; i < 10; i++) begin
            drive_req(vecs[i].src_b, vecs[i].op1, vecs[i].op2, vecs[i].opc);
            wait_grant(vecs[i].src_b);
            tick();
            a_valid = 1'b0;
            b_valid = 1'b0;
            check("exec_busy", busy, 1'b1);
            check("exec_eu_opcode", eu_opcode, vecs[i].opc);
            check("exec_eu_op1", eu_op1, vecs[i].op1);
            tick();
            if (vecs[i].src_b) begin
                check("vec_b_rsp_valid", b_rsp_valid, 1'b1);
                check("vec_b_result", b_rsp_result, vecs[i].exp_result);
                check("vec_b_branch", b_rsp_branch, vecs[i].exp_branch);
            end else begin
                check("vec_a_rsp_valid", a_rsp_valid, 1'b1);
                check("vec_a_result", a_rsp_result, vecs[i].exp_result);
                check("vec_a_branch", a_rsp_branch, vecs[i].exp_branch);
            end
            tick();
            check("vec_idle_busy", busy, 1'b0);
        end

        // round robin with both requesting continuously
        reset_dut();
        a_op1 = 32'd3;  a_op2 = 32'd4;  a_opcode = 7'd0;
        b_op1 = 32'd10; b_op2 = 32'd20; b_opcode = 7'd0;
        a_valid = 1'b1;
        b_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [1:0] exp_g;
            exp_g = (i % 2 != 0) ? 2'b00 : (((i / 2) % 2 == 0) ? 2'b10 : 2'b01);
            #1;
            check("rr_grant", {a_ready, b_ready}, exp_g);
            tick();
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        repeat (3) tick();

        // A response held by backpressure: only B is granted, A slot stays stable
        reset_dut();
        a_rsp_ready = 1'b0;
        drive_req(1'b0, 32'd6, 32'd7, 7'd0);
        wait_grant(1'b0);
        tick();
        b_op1 = 32'd40; b_op2 = 32'd2; b_opcode = 7'd0;
        b_valid = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            #1;
            check("bp_grant", {a_ready, b_ready}, (i % 2 == 0) ? 2'b01 : 2'b00);
            check("bp_a_rsp_valid", a_rsp_valid, 1'b1);
            check("bp_a_rsp_result", a_rsp_result, 32'd13);
            tick();
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        repeat (2) tick();
        a_rsp_ready = 1'b1;
        repeat (2) tick();
        check("bp_a_drained", a_rsp_valid, 1'b0);

        // reset during EXEC aborts the operation and re-favours A
        drive_req(1'b0, 32'd8, 32'd9, 7'd0);
        wait_grant(1'b0);
        tick();
        a_valid = 1'b0;
        check("abort_busy_before", busy, 1'b1);
        rst_n = 1'b0;
        tick();
        check("abort_busy_after", busy, 1'b0);
        check("abort_a_rsp_valid", a_rsp_valid, 1'b0);
        check("abort_a_ready_in_rst", a_ready, 1'b0);
        rst_n = 1'b1;
        a_op1 = 32'd1; a_op2 = 32'd1; a_opcode = 7'd0;
        b_op1 = 32'd2; b_op2 = 32'd2; b_opcode = 7'd0;
        a_valid = 1'b1;
        b_valid = 1'b1;
        #1;
        check("abort_next_grant", {a_ready, b_ready}, 2'b10);
        check("abort_no_rsp", a_rsp_valid, 1'b0);
        tick();
        a_valid = 1'b0;
        b_valid = 1'b0;
        repeat (4) tick();

        // back-to-back A with drain in the grant cycle
        drive_req(1'b0, 32'd1, 32'd2, 7'd0);
        wait_grant(1'b0);
        tick();
        a_op1 = 32'd4;
        a_op2 = 32'd5;
        tick();
        check("b2b_first_valid", a_rsp_valid, 1'b1);
        check("b2b_first_result", a_rsp_result, 32'd3);
        check("b2b_regrant", a_ready, 1'b1);
        tick();
        a_valid = 1'b0;
        tick();
        check("b2b_second_valid", a_rsp_valid, 1'b1);
        check("b2b_second_result", a_rsp_result, 32'd9);
        repeat (2) tick();

        check("sb_a_empty", 64'(exp_a_q.size()), 64'd0);
        check("sb_b_empty", 64'(exp_b_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
